// File: rtl/bmf_pkg.sv
// Shared definitions for the BMF H-stream decoder.
//  - Default latent (K) and output (M) widths.
//  - Reset basis matrix and reset semiring mask that reproduce the fixed
//    6->7 decoder: po0 = k0 ^ k4, po1..po5 = k0..k4, po6 = k5.
//  - Config address that selects the semiring mask instead of an H row.
//  - bmf_decode: reference decode of one latent vector at the default widths.
package bmf_pkg;

    localparam int BMF_K = 6;
    localparam int BMF_M = 7;

    // Row j of H lives at bits [j*M +: M]; bit i of a row feeds output column i.
    localparam logic [BMF_K*BMF_M-1:0] BMF_RESET_H   = 42'h202_1202_0203;
    localparam logic [BMF_M-1:0]       BMF_RESET_XOR = 7'b0000001;

    // cfg_addr 0..K-1 selects an H row, K selects the mask, anything above is ignored.
    localparam int CFG_ADDR_XOR = BMF_K;

    // Column i combines the latent bits selected by column i of H, using
    // parity when mask[i] is set and a plain OR otherwise.
    function automatic logic [BMF_M-1:0] bmf_decode(
        input logic [BMF_K-1:0]       k,
        input logic [BMF_K*BMF_M-1:0] h,
        input logic [BMF_M-1:0]       mask
    );
        logic [BMF_M-1:0] po;
        logic [BMF_K-1:0] m;
        po = '0;
        for (int i = 0; i < BMF_M; i++) begin
            m = '0;
            for (int j = 0; j < BMF_K; j++) begin
                m[j] = k[j] & h[j*BMF_M + i];
            end
            po[i] = mask[i] ? (^m) : (|m);
        end
        return po;
    endfunction

endpackage

// File: rtl/bmf_h_stream_decoder_fifo2.sv
// bmf_fifo2: two-entry skid FIFO with valid/ready on both sides.
//  clk, rst              clock and synchronous active-high reset
//  in_valid/in_ready     write side; in_ready is low only when both slots hold data
//  in_data   [W]         word to store
//  out_valid/out_ready   read side; out_valid whenever at least one word is held
//  out_data  [W]         oldest held word, zero when empty
// in_ready depends only on stored state, so there is no combinational path
// from out_ready back to in_ready. When full, a push cannot coincide with a pop.
module bmf_fifo2 #(
    parameter int W = 7
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data
);

    logic [W-1:0] mem_reg [2];
    logic         wr_ptr_reg;
    logic         rd_ptr_reg;
    logic [1:0]   count_reg;

    logic push;
    logic pop;

    assign in_ready  = (count_reg != 2'd2);
    assign out_valid = (count_reg != 2'd0);
    assign out_data  = out_valid ? mem_reg[rd_ptr_reg] : '0;

    assign push = in_valid & in_ready;
    assign pop  = out_valid & out_ready;

    // Storage needs no reset: its contents are only visible while count_reg > 0.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_reg[wr_ptr_reg] <= in_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_reg <= 1'b0;
            rd_ptr_reg <= 1'b0;
            count_reg  <= 2'd0;
        end else begin
            if (push) begin
                wr_ptr_reg <= ~wr_ptr_reg;
            end
            if (pop) begin
                rd_ptr_reg <= ~rd_ptr_reg;
            end
            // Simultaneous push and pop leaves the count unchanged.
            case ({push, pop})
                2'b10:   count_reg <= count_reg + 2'd1;
                2'b01:   count_reg <= count_reg - 2'd1;
                default: count_reg <= count_reg;
            endcase
        end
    end

endmodule

// File: rtl/bmf_h_stream_decoder.sv
// bmf_h_stream_decoder: streaming Boolean-matrix-factorization decompressor.
// Expands a K-bit latent vector to M outputs through a programmable K x M basis
// H, combining each output column over OR or XOR as selected by a mask.
//  clk, rst             clock, synchronous active-high reset
//  cfg_we/addr/data     config write: addr < K writes H row, addr == K writes mask
//  in_valid/in_ready    latent input handshake, in_k [K] latent vector
//  out_valid/out_ready  decoded output handshake, out_po [M] decoded vector
//  out_cnt [CNT_W]      completed output handshakes, wraps
// Vectors are decoded at acceptance and parked in a 2-entry FIFO, so later
// config writes never change words that are already queued.
module bmf_h_stream_decoder
    import bmf_pkg::*;
#(
    parameter int               K         = BMF_K,
    parameter int               M         = BMF_M,
    parameter logic [K*M-1:0]   RESET_H   = BMF_RESET_H,
    parameter logic [M-1:0]     RESET_XOR = BMF_RESET_XOR,
    parameter int               CNT_W     = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   cfg_we,
    input  logic [$clog2(K+1)-1:0] cfg_addr,
    input  logic [M-1:0]           cfg_data,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [K-1:0]           in_k,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [M-1:0]           out_po,
    output logic [CNT_W-1:0]       out_cnt
);

    localparam int AW = $clog2(K+1);

    logic [M-1:0]     h_reg [K];
    logic [M-1:0]     xor_mask_reg;
    logic [CNT_W-1:0] cnt_reg;
    logic [M-1:0]     po_next;

    // Config registers. A vector accepted on the same edge uses the values
    // present before this edge, because decode reads the current registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int j = 0; j < K; j++) begin
                h_reg[j] <= RESET_H[j*M +: M];
            end
            xor_mask_reg <= RESET_XOR;
        end else if (cfg_we) begin
            for (int j = 0; j < K; j++) begin
                if (cfg_addr == AW'(j)) begin
                    h_reg[j] <= cfg_data;
                end
            end
            if (cfg_addr == AW'(K)) begin
                xor_mask_reg <= cfg_data;
            end
        end
    end

    // Per-column decode: gather column gi of H, mask with the latent vector,
    // then reduce by parity or OR.
    genvar gi, gj;
    generate
        for (gi = 0; gi < M; gi++) begin : g_col
            logic [K-1:0] col;
            logic [K-1:0] m;
            for (gj = 0; gj < K; gj++) begin : g_row
                assign col[gj] = h_reg[gj][gi];
            end
            assign m           = in_k & col;
            assign po_next[gi] = xor_mask_reg[gi] ? (^m) : (|m);
        end
    endgenerate

    bmf_fifo2 #(
        .W(M)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (po_next),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_po)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_reg <= '0;
        end else if (out_valid && out_ready) begin
            cnt_reg <= cnt_reg + CNT_W'(1);
        end
    end

    assign out_cnt = cnt_reg;

endmodule
